// File: rtl/hazard_interlock_pkg.sv
// Shared decode constants, FSM state type and a source-vs-destination match helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_interlock_pkg;

  // Opcodes, instruction bits [31:27]
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  // R-type ALU ops, instruction bits [6:2]
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  // Implicit register operands
  localparam logic [4:0] REG_STATUS = 5'd30;
  localparam logic [4:0] REG_RA     = 5'd31;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // True when either valid source matches a valid destination.
  function automatic logic reads_reg(
    input logic       s1_v,
    input logic [4:0] s1,
    input logic       s2_v,
    input logic [4:0] s2,
    input logic       d_v,
    input logic [4:0] d
  );
    return d_v && ((s1_v && (s1 == d)) || (s2_v && (s2 == d)));
  endfunction

endpackage

// File: rtl/hazard_interlock_instr_regs_decode.sv
// Decodes one instruction register into its destination/source register usage.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
// Ports: ir_i (instruction); dest_valid_o/dest_o, src1_valid_o/src1_o,
//        src2_valid_o/src2_o, is_load_o (lw), is_muldiv_o (R-type mul/div).
module instr_regs_decode
  import hazard_interlock_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic        dest_valid_o,
  output logic [4:0]  dest_o,
  output logic        src1_valid_o,
  output logic [4:0]  src1_o,
  output logic        src2_valid_o,
  output logic [4:0]  src2_o,
  output logic        is_load_o,
  output logic        is_muldiv_o
);

  logic [4:0] opcode, rd, rs, rt, alu_op;
  logic       is_nop;
  logic       d_v, s1_v, s2_v;
  logic [4:0] d, s1, s2;

  assign opcode = ir_i[31:27];
  assign rd     = ir_i[26:22];
  assign rs     = ir_i[21:17];
  assign rt     = ir_i[16:12];
  assign alu_op = ir_i[6:2];
  assign is_nop = (ir_i == 32'd0);

  always_comb begin
    d_v  = 1'b0;
    d    = rd;
    s1_v = 1'b0;
    s1   = rs;
    s2_v = 1'b0;
    s2   = rt;
    if (!is_nop) begin
      case (opcode)
        OP_RTYPE: begin
          d_v  = 1'b1;
          s1_v = 1'b1;
          s2_v = 1'b1;
        end
        OP_ADDI, OP_LW: begin
          d_v  = 1'b1;
          s1_v = 1'b1;
        end
        OP_SETX: begin
          d_v = 1'b1;
          d   = REG_STATUS;
        end
        OP_JAL: begin
          d_v = 1'b1;
          d   = REG_RA;
        end
        // Stores and compares read the rd field as an operand
        OP_SW, OP_BNE, OP_BLT: begin
          s1_v = 1'b1;
          s1   = rd;
          s2_v = 1'b1;
          s2   = rs;
        end
        OP_JR: begin
          s1_v = 1'b1;
          s1   = rd;
        end
        OP_BEX: begin
          s1_v = 1'b1;
          s1   = REG_STATUS;
        end
        default: ;
      endcase
    end
  end

  // r0 is hardwired to zero, so it never carries a dependence.
  assign dest_valid_o = d_v  && (d  != 5'd0);
  assign dest_o       = d;
  assign src1_valid_o = s1_v && (s1 != 5'd0);
  assign src1_o       = s1;
  assign src2_valid_o = s2_v && (s2 != 5'd0);
  assign src2_o       = s2;
  assign is_load_o    = !is_nop && (opcode == OP_LW);
  assign is_muldiv_o  = (opcode == OP_RTYPE) && ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));

endmodule

// File: rtl/hazard_interlock.sv
// Pipeline interlock: RAW/load-use hazard stalls, mult/div issue FSM, stall counter.
// Latency: stall/bubble/start outputs are combinational; counter and timeout flag register on clock.
// Backpressure: md_ready releases the front-end freeze in the same cycle.
// Ports: clock, reset (async active-high); fd/dx/xm/mw_ir pipeline IRs; md_ready in;
//        md_start, freeze_front, stall_fd, bubble_dx, bubble_xm, md_busy, md_timeout, stall_count out.
module hazard_interlock
  import hazard_interlock_pkg::*;
#(
  parameter int FORWARDING = 1,
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      fd_ir,
  input  logic [31:0]      dx_ir,
  input  logic [31:0]      xm_ir,
  input  logic [31:0]      mw_ir,
  input  logic             md_ready,
  output logic             md_start,
  output logic             freeze_front,
  output logic             stall_fd,
  output logic             bubble_dx,
  output logic             bubble_xm,
  output logic             md_busy,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int TMR_W = $clog2(MD_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MD_TIMEOUT - 1);

  // Per-stage decode
  logic       fd_d_v, fd_s1_v, fd_s2_v, fd_ld, fd_md;
  logic [4:0] fd_d, fd_s1, fd_s2;
  logic       dx_d_v, dx_s1_v, dx_s2_v, dx_ld, dx_md;
  logic [4:0] dx_d, dx_s1, dx_s2;
  logic       xm_d_v, xm_s1_v, xm_s2_v, xm_ld, xm_md;
  logic [4:0] xm_d, xm_s1, xm_s2;
  logic       mw_d_v, mw_s1_v, mw_s2_v, mw_ld, mw_md;
  logic [4:0] mw_d, mw_s1, mw_s2;

  instr_regs_decode u_dec_fd (.ir_i(fd_ir), .dest_valid_o(fd_d_v), .dest_o(fd_d),
    .src1_valid_o(fd_s1_v), .src1_o(fd_s1), .src2_valid_o(fd_s2_v), .src2_o(fd_s2),
    .is_load_o(fd_ld), .is_muldiv_o(fd_md));
  instr_regs_decode u_dec_dx (.ir_i(dx_ir), .dest_valid_o(dx_d_v), .dest_o(dx_d),
    .src1_valid_o(dx_s1_v), .src1_o(dx_s1), .src2_valid_o(dx_s2_v), .src2_o(dx_s2),
    .is_load_o(dx_ld), .is_muldiv_o(dx_md));
  instr_regs_decode u_dec_xm (.ir_i(xm_ir), .dest_valid_o(xm_d_v), .dest_o(xm_d),
    .src1_valid_o(xm_s1_v), .src1_o(xm_s1), .src2_valid_o(xm_s2_v), .src2_o(xm_s2),
    .is_load_o(xm_ld), .is_muldiv_o(xm_md));
  instr_regs_decode u_dec_mw (.ir_i(mw_ir), .dest_valid_o(mw_d_v), .dest_o(mw_d),
    .src1_valid_o(mw_s1_v), .src1_o(mw_s1), .src2_valid_o(mw_s2_v), .src2_o(mw_s2),
    .is_load_o(mw_ld), .is_muldiv_o(mw_md));

  // Decode fields this block has no use for
  logic unused_dec;
  assign unused_dec = ^{fd_d_v, fd_d, fd_ld, fd_md, dx_s1_v, dx_s1, dx_s2_v, dx_s2,
                        xm_s1_v, xm_s1, xm_s2_v, xm_s2, xm_ld, xm_md,
                        mw_s1_v, mw_s1, mw_s2_v, mw_s2, mw_ld, mw_md};

  // Hazard detection
  logic raw_any, load_use, hazard;
  assign raw_any  = reads_reg(fd_s1_v, fd_s1, fd_s2_v, fd_s2, dx_d_v, dx_d)
                  | reads_reg(fd_s1_v, fd_s1, fd_s2_v, fd_s2, xm_d_v, xm_d)
                  | reads_reg(fd_s1_v, fd_s1, fd_s2_v, fd_s2, mw_d_v, mw_d);
  // With forwarding only a load result is too late to bypass into execute.
  assign load_use = dx_ld && reads_reg(fd_s1_v, fd_s1, fd_s2_v, fd_s2, dx_d_v, dx_d);
  assign hazard   = (FORWARDING != 0) ? load_use : raw_any;

  // Mult/div FSM
  md_state_e        state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             md_stall;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    timeout_d = timeout_q;
    md_start  = 1'b0;
    md_stall  = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (dx_md) begin
          md_start = 1'b1;
          md_stall = 1'b1;
          state_d  = MD_BUSY;
          timer_d  = '0;
        end
      end
      MD_BUSY: begin
        // Ready releases the freeze this cycle so the op advances with its result.
        if (md_ready) begin
          state_d = MD_IDLE;
        end else begin
          md_stall = 1'b1;
          if (timer_q == TMR_LAST) begin
            state_d   = MD_IDLE;
            timeout_d = 1'b1;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // Mult/div freeze dominates: a pending hazard is re-evaluated after release.
  assign stall_fd     = hazard && !md_stall;
  assign bubble_dx    = stall_fd;
  assign freeze_front = md_stall;
  assign bubble_xm    = md_stall;
  assign md_busy      = (state_q == MD_BUSY);
  assign md_timeout   = timeout_q;
  assign stall_count  = count_q;

  always_comb begin
    count_d = count_q;
    if ((stall_fd || md_stall) && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

endmodule
